// File: rtl/coherent_memory_control.sv
// coherent_memory_control: responder end of the two-CPU cache interface.
// Arbitrates instruction fetches, data fills and write-backs from two caches onto one
// single-ported RAM. Drives MSI snoop/invalidate/wait signals. Forwards dirty words
// cache-to-cache while the same word is written to RAM.
// Build option: define MEMCTRL_RR_EN to enable a round-robin tie-break pointer.
// If it is not defined, CPU0 wins ties.
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
module coherent_memory_control #(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    input  logic [CPUS-1:0]              ccwrite,
    input  logic [CPUS-1:0]              cctrans,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  iload,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    output logic [CPUS-1:0]              ccwait,
    output logic [CPUS-1:0]              ccinv,
    output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  logic [1:0]                   ramstate
);

    localparam logic [1:0] RamAccess = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StIfetch,
        StWb,
        StSnoop,
        StFillRam,
        StFillC2c
    } state_e;

    state_e state_q;
    logic   grant_q;   // CPU currently owning the RAM
    logic   done_q;    // a completion pulse is being presented this cycle
    logic   snooper;   // the non-granted CPU
    logic   cur_req;   // granted request line for the current state

    state_e arb_state;
    logic   arb_grant;
    logic [CPUS-1:0] arb_req;

    // cctrans is informational only
    logic unused_cctrans;
    assign unused_cctrans = ^cctrans;

    assign snooper = ~grant_q;

`ifdef MEMCTRL_RR_EN
    logic rr_q;

    // Tie-break by the round-robin pointer
    function automatic logic pick(input logic [1:0] req, input logic pref);
        if (req == 2'b11) return pref;
        return req[0] ? 1'b0 : 1'b1;
    endfunction
`else
    // Fixed priority: CPU0 wins ties
    function automatic logic pick(input logic [1:0] req);
        return req[0] ? 1'b0 : 1'b1;
    endfunction
`endif

    // Class priority dWEN > dREN > iREN, then CPU selection within the class
    always_comb begin
        arb_state = StIdle;
        arb_req   = '0;
        if (|dWEN) begin
            arb_state = StWb;
            arb_req   = dWEN;
        end else if (|dREN) begin
            arb_state = StSnoop;
            arb_req   = dREN;
        end else if (|iREN) begin
            arb_state = StIfetch;
            arb_req   = iREN;
        end
`ifdef MEMCTRL_RR_EN
        arb_grant = pick(arb_req, rr_q);
`else
        arb_grant = pick(arb_req);
`endif
    end

    // Request line that holds the current grant
    always_comb begin
        cur_req = 1'b0;
        case (state_q)
            StIfetch:                    cur_req = iREN[grant_q];
            StWb:                        cur_req = dWEN[grant_q];
            StSnoop, StFillRam, StFillC2c: cur_req = dREN[grant_q];
            default:                     cur_req = 1'b0;
        endcase
    end

    // Controller FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            done_q      <= 1'b0;
            iwait       <= '1;
            dwait       <= '1;
            iload       <= '0;
            dload       <= '0;
            ccwait      <= '0;
            ccinv       <= '0;
            ccsnoopaddr <= '0;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
            ramaddr     <= '0;
            ramstore    <= '0;
`ifdef MEMCTRL_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            // Completion pulses last exactly one cycle
            iwait <= '1;
            dwait <= '1;
            case (state_q)
                StIdle: begin
                    ccwait <= '0;
                    ccinv  <= '0;
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                    done_q <= 1'b0;
                    if (arb_state != StIdle) begin
                        state_q <= arb_state;
                        grant_q <= arb_grant;
                        if (arb_state == StWb) begin
                            ramWEN   <= 1'b1;
                            ramaddr  <= daddr[arb_grant];
                            ramstore <= dstore[arb_grant];
                        end else if (arb_state == StSnoop) begin
                            ccwait[~arb_grant]      <= 1'b1;
                            ccsnoopaddr[~arb_grant] <= daddr[arb_grant];
                            ccinv[~arb_grant]       <= ccwrite[arb_grant];
                        end else begin
                            ramREN  <= 1'b1;
                            ramaddr <= iaddr[arb_grant];
                        end
                    end
                end
                default: begin
                    if (state_q == StSnoop || state_q == StFillRam || state_q == StFillC2c) begin
                        ccsnoopaddr[snooper] <= daddr[grant_q];
                    end
                    if (!cur_req) begin
                        // Grant released: drop everything and let IDLE re-arbitrate
                        state_q <= StIdle;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        ccwait  <= '0;
                        ccinv   <= '0;
                        done_q  <= 1'b0;
`ifdef MEMCTRL_RR_EN
                        rr_q    <= ~grant_q;
`endif
                    end else if (state_q == StSnoop) begin
                        // Snooper answers hit-dirty: source the word from its cache
                        if (ccwrite[snooper]) begin
                            state_q  <= StFillC2c;
                            ramWEN   <= 1'b1;
                            ramaddr  <= daddr[grant_q];
                            ramstore <= dstore[snooper];
                        end else begin
                            state_q <= StFillRam;
                            ramREN  <= 1'b1;
                            ramaddr <= daddr[grant_q];
                        end
                    end else if (done_q) begin
                        // Request still held after a completion: next word of the burst
                        done_q <= 1'b0;
                        case (state_q)
                            StIfetch: begin
                                ramREN  <= 1'b1;
                                ramaddr <= iaddr[grant_q];
                            end
                            StWb: begin
                                ramWEN   <= 1'b1;
                                ramaddr  <= daddr[grant_q];
                                ramstore <= dstore[grant_q];
                            end
                            StFillRam: begin
                                ramREN  <= 1'b1;
                                ramaddr <= daddr[grant_q];
                            end
                            StFillC2c: begin
                                ramWEN   <= 1'b1;
                                ramaddr  <= daddr[grant_q];
                                ramstore <= dstore[snooper];
                            end
                            default: ;
                        endcase
                    end else if (ramstate == RamAccess) begin
                        // BUSY/FREE/ERROR fall through: enables and addresses held
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        done_q <= 1'b1;
                        case (state_q)
                            StIfetch: begin
                                iwait[grant_q] <= 1'b0;
                                iload[grant_q] <= ramload;
                            end
                            StWb: begin
                                dwait[grant_q] <= 1'b0;
                            end
                            StFillRam: begin
                                dwait[grant_q] <= 1'b0;
                                dload[grant_q] <= ramload;
                            end
                            StFillC2c: begin
                                dwait[grant_q] <= 1'b0;
                                dwait[snooper] <= 1'b0;
                                dload[grant_q] <= ramstore;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
